// File: rtl/seq_alu_if.sv
// Operation/result bus between decode/register-read and the sequential ALU.
// master drives operands and consumes results; slave is the ALU side.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] value1;
    logic [WIDTH-1:0] value2;
    logic [5:0]       opcode;
    logic [5:0]       func;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             div_zero;
    logic             bad_op;

    modport master (
        output in_valid, value1, value2, opcode, func, out_ready,
        input  in_ready, out_valid, result, zero, div_zero, bad_op
    );

    modport slave (
        input  in_valid, value1, value2, opcode, func, out_ready,
        output in_ready, out_valid, result, zero, div_zero, bad_op
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle MIPS ALU: 1-cycle simple ops, WIDTH+1-cycle shift-add multiply / restoring divide.
// Accepts only in IDLE; result and flags hold in DONE until out_ready.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic        clk,
    input logic        rst_n,
    seq_alu_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_rem_q, is_rem_d;
    logic             zero_q, zero_d, div_zero_q, div_zero_d, bad_op_q, bad_op_d;

    logic [WIDTH-1:0] dec_res;
    logic             dec_bad, dec_mul, dec_div, dec_rem, dec_dz;
    logic [WIDTH-1:0] mul_acc, div_rem, div_quo, div_res;
    logic [WIDTH:0]   rem_sh;
    logic             div_fits, last_step;

    // Decode plus the single-cycle result, including the divide-by-zero shortcut.
    always_comb begin
        dec_res = '0;
        dec_bad = 1'b0;
        dec_mul = 1'b0;
        dec_div = 1'b0;
        dec_rem = 1'b0;
        dec_dz  = 1'b0;
        if (bus.opcode == 6'd0) begin
            case (bus.func)
                6'd32: dec_res = bus.value1 + bus.value2;
                6'd33: dec_res = bus.value1 - bus.value2;
                6'd36: dec_res = bus.value1 & bus.value2;
                6'd37: dec_res = bus.value1 | bus.value2;
                6'd42: dec_res = {{(WIDTH-1){1'b0}}, $signed(bus.value1) < $signed(bus.value2)};
                6'd24: dec_mul = 1'b1;
                6'd26, 6'd27: begin
                    dec_div = 1'b1;
                    dec_rem = (bus.func == 6'd27);
                    dec_dz  = (bus.value2 == '0);
                    dec_res = dec_rem ? bus.value1 : '1;
                end
                default: dec_bad = 1'b1;
            endcase
        end else begin
            case (bus.opcode)
                6'd8:    dec_res = bus.value1 + bus.value2;
                6'd9:    dec_res = bus.value1 - bus.value2;
                6'd12:   dec_res = bus.value1 & bus.value2;
                6'd13:   dec_res = bus.value1 | bus.value2;
                default: dec_bad = 1'b1;
            endcase
        end
    end

    // One iteration step; a_q doubles as multiplicand and as dividend/quotient shifter.
    always_comb begin
        mul_acc   = acc_q + (b_q[0] ? a_q : '0);
        rem_sh    = {acc_q, a_q[WIDTH-1]};
        div_fits  = rem_sh >= {1'b0, b_q};
        div_rem   = div_fits ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
        div_quo   = {a_q[WIDTH-2:0], div_fits};
        div_res   = is_rem_q ? div_rem : div_quo;
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            is_rem_q   <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            div_zero_q <= 1'b0;
            bad_op_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            is_rem_q   <= is_rem_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            div_zero_q <= div_zero_d;
            bad_op_q   <= bad_op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                if (dec_mul)                 state_d = MUL;
                else if (dec_div && !dec_dz) state_d = DIV;
                else                         state_d = DONE;
            end
            MUL:  if (last_step) state_d = DONE;
            DIV:  if (last_step) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        is_rem_d   = is_rem_q;
        result_d   = result_q;
        zero_d     = zero_q;
        div_zero_d = div_zero_q;
        bad_op_d   = bad_op_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d        = bus.value1;
                b_d        = bus.value2;
                acc_d      = '0;
                cnt_d      = '0;
                is_rem_d   = dec_rem;
                result_d   = dec_res;
                zero_d     = (dec_res == '0);
                div_zero_d = dec_dz;
                bad_op_d   = dec_bad;
            end
            MUL: begin
                acc_d = mul_acc;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    result_d = mul_acc;
                    zero_d   = (mul_acc == '0);
                end
            end
            DIV: begin
                acc_d = div_rem;
                a_d   = div_quo;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    result_d = div_res;
                    zero_d   = (div_res == '0);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.result    = result_q;
        bus.zero      = zero_q;
        bus.div_zero  = div_zero_q;
        bus.bad_op    = bad_op_q;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the combinational MIPS ALU.
- Covers the existing R-type and I-type operations with one-cycle registered latency.
- Adds an iterative shift-add multiplier, an unsigned restoring divider, a signed set-less-than, and status flags.
- Sits between the decode/register-read stage and writeback. Uses valid/ready handshakes so the pipeline can stall on long operations.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands/opcode/func valid this cycle.
- in_ready  output  1  block can accept an operation.
- value1  input  WIDTH  operand A (rs).
- value2  input  WIDTH  operand B (rt or sign-extended immediate).
- opcode  input  6  MIPS opcode.
- func  input  6  MIPS funct field; used only when opcode==0.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- div_zero  output  1  divide/remainder issued with value2 == 0.
- bad_op  output  1  unsupported opcode/func combination.

Behaviour:
- Reset (clk edge with rst_n==0), which overrides everything:
  - state=IDLE.
  - in_ready=1 (combinational from state).
  - out_valid=0, result=0, zero=0, div_zero=0, bad_op=0.
  - Internal accumulator, quotient, remainder and counter cleared.
- Operation decode:
  - opcode 0, func 32: A+B.
  - opcode 0, func 33: A-B.
  - opcode 0, func 36: A&B.
  - opcode 0, func 37: A|B.
  - opcode 0, func 42: signed A<B gives 1, else 0.
  - opcode 0, func 24: low WIDTH bits of unsigned A*B.
  - opcode 0, func 26: unsigned A/B.
  - opcode 0, func 27: unsigned A%B.
  - opcode 8: A+B. opcode 9: A-B. opcode 12: A&B. opcode 13: A|B.
  - All other combinations: result=0, bad_op=1.
- Arithmetic is modulo 2^WIDTH. No overflow trap; carries are discarded.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, latch the operands.
    - Single-cycle op or bad op: compute the result, go to DONE.
    - func 24: go to MUL.
    - func 26/27 with B!=0: go to DIV.
    - func 26/27 with B==0: go directly to DONE with quotient all-ones (func 26) or remainder=A (func 27), and div_zero=1.
  - MUL: one shift-add step per cycle (test B bit 0, add shifted A, shift). Exactly WIDTH cycles, then DONE.
  - DIV: one restoring step per cycle, MSB first. Exactly WIDTH cycles, then DONE.
  - DONE: out_valid=1, in_ready=0. result and flags are held stable until out_ready=1. On the out_ready edge go to IDLE with out_valid=0.
- Latency from the accept edge to out_valid high:
  - Single-cycle ops: 1 cycle.
  - MUL/DIV: WIDTH+1 cycles.
  - Divide by zero: 1 cycle.
- No overlap: a new operation is accepted only in IDLE. in_valid is ignored while in MUL, DIV or DONE, and inputs may change freely then.
- zero is computed from the final result. div_zero and bad_op are cleared on every accept.
- Reset mid-MUL/DIV: the operation is aborted, and the partial result is never presented.
- Counter reaching WIDTH-1 is the terminal step. No off-by-one: exactly WIDTH iterations.

Test Plan:
- Reset, then opcode 0 func 32, A=5, B=7 -> out_valid 1 cycle after accept, result=12, zero=0. Then opcode 9, A=3, B=5 -> result=0xFFFFFFFE.
- func 24, A=123, B=456 -> out_valid exactly 33 cycles after accept, result=56088. Then A=B=0x00010000 -> result=0, zero=1.
- func 26, A=100, B=7 -> 14. func 27 with the same operands -> 2. func 26, B=0 -> result=0xFFFFFFFF, div_zero=1 after 1 cycle.
- func 42: A=0xFFFFFFFF, B=1 -> result 1. opcode 5 (unsupported) -> result=0, bad_op=1.
- Backpressure: hold out_ready=0 for 10 cycles after an add completes -> result, flags and out_valid stay stable and in_ready=0. A new in_valid pulse is ignored. Releasing out_ready returns to IDLE next cycle.
- Assert rst_n=0 at cycle 10 of a multiply -> next cycle out_valid=0, in_ready=1, result=0. A following add 1+1 returns 2 normally.
